alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_if.sv | 21 ++
 rtl/alu_mul_seq.sv | 153 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// Request/response bundle between the execute-stage controller and the
// shift-and-add multiply sequencer.
interface alu_mul_seq_if;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ofl;

    modport master (
        output start, op_a, op_b,
        input  busy, done, product, ofl
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, product, ofl
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned 16x16 multiply (low 16 bits + exact overflow) built as a
// shift-and-add loop that borrows the shared execute-stage ALU one op per cycle.
module alu_mul_seq (
    input  logic          clk,
    input  logic          rst_n,
    alu_mul_seq_if.slave  bus,
    output logic          alu_own,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output logic [2:0]    alu_op,
    output logic          alu_cin,
    output logic          alu_inva,
    output logic          alu_invb,
    output logic          alu_sign,
    input  logic [15:0]   alu_out,
    input  logic          alu_ofl,
    input  logic          alu_z
);
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHM, S_SHQ, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [15:0] acc_reg, acc_next;
    logic [15:0] mcand_reg, mcand_next;
    logic [15:0] mplier_reg, mplier_next;
    logic        ofl_r_reg, ofl_r_next;

    logic        busy_reg, done_reg, ofl_reg, alu_own_reg;
    logic [15:0] product_reg, alu_a_reg, alu_b_reg;
    logic [2:0]  alu_op_reg;

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        ofl_r_next  = ofl_r_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    acc_next    = 16'd0;
                    mcand_next  = bus.op_a;
                    mplier_next = bus.op_b;
                    ofl_r_next  = 1'b0;
                    if (bus.op_b == 16'd0)
                        state_next = S_DONE;
                    else if (bus.op_b[0])
                        state_next = S_ADD;
                    else
                        state_next = S_SHM;
                end
            end
            S_ADD: begin
                acc_next   = alu_out;
                ofl_r_next = ofl_r_reg | alu_ofl;
                state_next = S_SHM;
            end
            S_SHM: begin
                mcand_next = alu_out;
                // A multiplicand bit shifted out only matters if a higher
                // multiplier bit is still going to add it in.
                if (mcand_reg[15] && (mplier_reg[15:1] != 15'd0))
                    ofl_r_next = 1'b1;
                state_next = S_SHQ;
            end
            S_SHQ: begin
                mplier_next = alu_out;
                if (alu_z)
                    state_next = S_DONE;
                else if (alu_out[0])
                    state_next = S_ADD;
                else
                    state_next = S_SHM;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so that the ALU drive
    // seen in each state is already stable at the start of that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            acc_reg     <= 16'd0;
            mcand_reg   <= 16'd0;
            mplier_reg  <= 16'd0;
            ofl_r_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= 16'd0;
            ofl_reg     <= 1'b0;
            alu_own_reg <= 1'b0;
            alu_a_reg   <= 16'd0;
            alu_b_reg   <= 16'd0;
            alu_op_reg  <= OP_NONE;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            ofl_r_reg   <= ofl_r_next;
            busy_reg    <= (state_next != S_IDLE);
            done_reg    <= (state_next == S_DONE);
            alu_own_reg <= (state_next == S_ADD) || (state_next == S_SHM) ||
                           (state_next == S_SHQ);
            if (state_next == S_DONE) begin
                product_reg <= acc_next;
                ofl_reg     <= ofl_r_next;
            end
            case (state_next)
                S_ADD: begin
                    alu_a_reg  <= acc_next;
                    alu_b_reg  <= mcand_next;
                    alu_op_reg <= OP_ADD;
                end
                S_SHM: begin
                    alu_a_reg  <= mcand_next;
                    alu_b_reg  <= 16'h0001;
                    alu_op_reg <= OP_SLL;
                end
                S_SHQ: begin
                    alu_a_reg  <= mplier_next;
                    alu_b_reg  <= 16'h0001;
                    alu_op_reg <= OP_SRL;
                end
                default: begin
                    alu_a_reg  <= 16'd0;
                    alu_b_reg  <= 16'd0;
                    alu_op_reg <= OP_NONE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;
    assign bus.ofl     = ofl_reg;

    assign alu_own  = alu_own_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign alu_op   = alu_op_reg;
    assign alu_cin  = 1'b0;
    assign alu_inva = 1'b0;
    assign alu_invb = 1'b0;
    assign alu_sign = 1'b0;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed vector table, multi-cycle corner sequences and a random sweep
// for the ALU-sharing multiply sequencer, with a behavioural ALU alongside.
module tb_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_own, alu_cin, alu_inva, alu_invb, alu_sign;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_ofl, alu_z;

    alu_mul_seq_if bus();

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_inva(alu_inva), .alu_invb(alu_invb),
        .alu_sign(alu_sign), .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_z(alu_z)
    );

    always #5 clk = ~clk;

    // Shared ALU: only the opcodes the sequencer uses.
    always_comb begin
        logic [16:0] sum;
        sum     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = 16'd0;
        alu_ofl = 1'b0;
        case (alu_op)
            3'd1: alu_out = alu_a << alu_b[3:0];
            3'd3: alu_out = alu_a >> alu_b[3:0];
            3'd4: begin alu_out = sum[15:0]; alu_ofl = sum[16]; end
            default: alu_out = 16'd0;
        endcase
        alu_z = (alu_out == 16'd0);
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int viol   = 0;

    // ALU drive invariants, checked every cycle.
    always @(negedge clk) begin
        if (alu_cin || alu_inva || alu_invb || alu_sign) viol++;
        if (!alu_own && (alu_a != 16'd0 || alu_b != 16'd0 || alu_op != 3'd0)) viol++;
        if (alu_own && (!bus.busy || bus.done)) viol++;
        if (alu_own && !(alu_op == 3'd1 || alu_op == 3'd3 || alu_op == 3'd4)) viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one multiply and wait for done; lat counts edges from the start edge.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] prod, output logic ofl, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: no done for %0h*%0h after %0d cycles", a, b, lat);
            lat = -1;
        end
        prod = bus.product;
        ofl  = bus.ofl;
    endtask

    function automatic int model_lat(input logic [15:0] b);
        int l = 1;
        int msb = -1;
        for (int i = 0; i < 16; i++) if (b[i]) msb = i;
        for (int i = 0; i <= msb; i++) l += 2 + int'(b[i]);
        return l;
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        logic        ofl;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [15:0] prod;
        logic        ofl;
        int          lat;
        int          n_done, n_busy, prod_bad;
        logic [15:0] ra, rb;
        logic [31:0] full;

        vecs[0]  = '{16'h0007, 16'h0005, 16'h0023, 1'b0,  9};
        vecs[1]  = '{16'h1234, 16'h0000, 16'h0000, 1'b0,  1};
        vecs[2]  = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 49};
        vecs[3]  = '{16'h8000, 16'h0003, 16'h8000, 1'b1,  7};
        vecs[4]  = '{16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 21};
        vecs[5]  = '{16'h8000, 16'h0002, 16'h0000, 1'b1,  6};
        vecs[6]  = '{16'hC000, 16'h0001, 16'hC000, 1'b0,  4};
        vecs[7]  = '{16'h0003, 16'h0003, 16'h0009, 1'b0,  7};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 49};
        vecs[9]  = '{16'h0100, 16'h0100, 16'h0000, 1'b1, 20};
        vecs[10] = '{16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 25};
        vecs[11] = '{16'h0001, 16'h8000, 16'h8000, 1'b0, 34};
        vecs[12] = '{16'h0002, 16'h8000, 16'h0000, 1'b1, 34};
        vecs[13] = '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0,  4};
        vecs[14] = '{16'h1234, 16'h5678, 16'h0060, 1'b1, 39};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_a = 16'd0; bus.op_b = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",    {31'd0, bus.busy}, 32'd0);
        check("reset_done",    {31'd0, bus.done}, 32'd0);
        check("reset_product", {16'd0, bus.product}, 32'd0);
        check("reset_ofl",     {31'd0, bus.ofl}, 32'd0);
        check("reset_alu_own", {31'd0, alu_own}, 32'd0);
        check("reset_alu_drv", {alu_a, alu_b[12:0], alu_op}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_mul(vecs[i].a, vecs[i].b, prod, ofl, lat);
            $display("vec %0d: %04h*%04h -> product %04h ofl %0d lat %0d",
                     i, vecs[i].a, vecs[i].b, prod, ofl, lat);
            check($sformatf("vec%0d_product", i), {16'd0, prod}, {16'd0, vecs[i].prod});
            check($sformatf("vec%0d_ofl", i), {31'd0, ofl}, {31'd0, vecs[i].ofl});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Asynchronous reset in the middle of a multiply (first SHM of 7*5).
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'h0007; bus.op_b = 16'h0005;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!(alu_own && alu_op == 3'd1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("reset_reached_shm", {31'd0, alu_own && alu_op == 3'd1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",    {31'd0, bus.busy}, 32'd0);
        check("midrst_alu_own", {31'd0, alu_own}, 32'd0);
        check("midrst_alu_drv", {alu_a, alu_b[12:0], alu_op}, 32'd0);
        check("midrst_product", {16'd0, bus.product}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0; n_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (bus.busy) n_busy++;
        end
        check("midrst_no_done", n_done, 0);
        check("midrst_idle", n_busy, 0);
        run_mul(16'h0007, 16'h0005, prod, ofl, lat);
        $display("post-reset 7*5 -> product %04h ofl %0d lat %0d", prod, ofl, lat);
        check("postrst_product", {16'd0, prod}, 32'h23);
        check("postrst_ofl", {31'd0, ofl}, 32'd0);
        check("postrst_latency", lat, 9);

        // Start held high every cycle while busy, including the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'h8000; bus.op_b = 16'h0003;
        n_done = 0; prod_bad = 0; lat = 0;
        while (n_done == 0 && lat < 40) begin
            @(negedge clk);
            lat++;
            bus.op_a = 16'(lat + 1); bus.op_b = 16'(lat + 1);
            if (bus.done) n_done++;
            else if (bus.product !== 16'h0023) prod_bad++;
        end
        prod = bus.product;
        ofl  = bus.ofl;
        @(negedge clk);
        bus.start = 1'b0;
        check("hs_after_done_idle", {31'd0, bus.busy}, 32'd0);
        repeat (6) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (bus.busy) prod_bad++;
        end
        $display("handshake 8000*3 -> product %04h ofl %0d lat %0d dones %0d", prod, ofl, lat, n_done);
        check("hs_done_once", n_done, 1);
        check("hs_product_held", prod_bad, 0);
        check("hs_product", {16'd0, prod}, 32'h8000);
        check("hs_ofl", {31'd0, ofl}, 32'd1);
        check("hs_latency", lat, 7);

        // Random sweep against an arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            full = 32'(ra) * 32'(rb);
            run_mul(ra, rb, prod, ofl, lat);
            if (i < 5)
                $display("rand %0d: %04h*%04h -> product %04h ofl %0d lat %0d", i, ra, rb, prod, ofl, lat);
            check($sformatf("rand%0d_product", i), {16'd0, prod}, {16'd0, full[15:0]});
            check($sformatf("rand%0d_ofl", i), {31'd0, ofl}, {31'd0, (full[31:16] != 16'd0)});
            check($sformatf("rand%0d_latency", i), lat, model_lat(rb));
        end

        check("alu_drive_invariants", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
